// File: rtl/switch_accum_pkg.sv
// Shared types and helpers for the switch-driven accumulator.
package switch_accum_pkg;

    // Control FSM: idle and ready, or waiting for every button to be released.
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_REL = 1'b1
    } accum_state_t;

    // Operation selected from the debounced button levels.
    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2,
        OP_CLR  = 2'd3
    } accum_op_t;

    // Width of a counter that must reach limit-1 (at least one bit).
    function automatic int unsigned dbc_cnt_width(input int unsigned limit);
        int unsigned w;
        w = $clog2(limit);
        if (w < 32'd1) begin
            return 32'd1;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser followed by a level debouncer for one push-button.
// The debounced level only follows the synchronised input after it has
// disagreed with it for DEBOUNCE_LIMIT consecutive cycles.
module switch_debounce
    import switch_accum_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Sw,
    output logic o_Level
);

    localparam int unsigned     CNT_W   = dbc_cnt_width(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;

    // Bring the bouncy asynchronous button into the clock domain.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= i_Sw;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreeing cycles; flip the level once the run is long enough.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = ~level_q;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Debounce counter and accepted level.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign o_Level = level_q;

endmodule

// File: rtl/switch_accum_adder.sv
// Clocked accumulator driven by operand switches and debounced add / subtract /
// clear buttons. One press executes exactly one operation; the FSM then waits
// until every button has been released before accepting another.
module switch_accum_adder
    import switch_accum_pkg::*;
#(
    parameter int unsigned WIDTH          = 2,
    parameter int unsigned DEBOUNCE_LIMIT = 250000,
    parameter int unsigned SATURATE       = 0
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic [WIDTH-1:0] i_Operand,
    input  logic             i_Add_Sw,
    input  logic             i_Sub_Sw,
    input  logic             i_Clr_Sw,
    output logic [WIDTH-1:0] o_LED_Sum,
    output logic             o_LED_Carry,
    output logic             o_Busy
);

    localparam bit SAT_EN = (SATURATE != 32'd0);

    logic [WIDTH-1:0] opd_sync1_q;
    logic [WIDTH-1:0] opd_sync2_q;
    logic             add_lvl_s;
    logic             sub_lvl_s;
    logic             clr_lvl_s;
    logic             any_btn_s;
    logic             execute_s;
    accum_state_t     state_q;
    accum_state_t     state_d;
    accum_op_t        op_s;
    logic [WIDTH:0]   add_ext_s;
    logic [WIDTH:0]   sub_ext_s;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             carry_q;
    logic             carry_d;

    // Operand switches only need metastability protection, not debouncing.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            opd_sync1_q <= '0;
            opd_sync2_q <= '0;
        end else begin
            opd_sync1_q <= i_Operand;
            opd_sync2_q <= opd_sync1_q;
        end
    end

    switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_db_add (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Sw    (i_Add_Sw),
        .o_Level (add_lvl_s)
    );

    switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_db_sub (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Sw    (i_Sub_Sw),
        .o_Level (sub_lvl_s)
    );

    switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_db_clr (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Sw    (i_Clr_Sw),
        .o_Level (clr_lvl_s)
    );

    assign any_btn_s = add_lvl_s | sub_lvl_s | clr_lvl_s;
    assign execute_s = (state_q == IDLE) && any_btn_s;

    // FSM state register.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Leave IDLE on any press; return once every button is released.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_btn_s) begin
                    state_d = WAIT_REL;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_REL: begin
                if (!any_btn_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_REL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Resolve simultaneous presses: clear wins, add+sub cancels, then add, then sub.
    always_comb begin
        op_s = OP_NONE;
        if (clr_lvl_s) begin
            op_s = OP_CLR;
        end else if (add_lvl_s && sub_lvl_s) begin
            op_s = OP_NONE;
        end else if (add_lvl_s) begin
            op_s = OP_ADD;
        end else if (sub_lvl_s) begin
            op_s = OP_SUB;
        end else begin
            op_s = OP_NONE;
        end
    end

    // One-bit-wider arithmetic so the top bit is the carry or the borrow.
    always_comb begin
        add_ext_s = {1'b0, sum_q} + {1'b0, opd_sync2_q};
        sub_ext_s = {1'b0, sum_q} - {1'b0, opd_sync2_q};
    end

    // Next accumulator and flag; only changes in the single execute cycle.
    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        if (execute_s) begin
            case (op_s)
                OP_CLR: begin
                    sum_d   = '0;
                    carry_d = 1'b0;
                end
                OP_ADD: begin
                    carry_d = add_ext_s[WIDTH];
                    if (SAT_EN && add_ext_s[WIDTH]) begin
                        sum_d = '1;
                    end else begin
                        sum_d = add_ext_s[WIDTH-1:0];
                    end
                end
                OP_SUB: begin
                    carry_d = sub_ext_s[WIDTH];
                    if (SAT_EN && sub_ext_s[WIDTH]) begin
                        sum_d = '0;
                    end else begin
                        sum_d = sub_ext_s[WIDTH-1:0];
                    end
                end
                OP_NONE: begin
                    sum_d   = sum_q;
                    carry_d = carry_q;
                end
                default: begin
                    sum_d   = sum_q;
                    carry_d = carry_q;
                end
            endcase
        end else begin
            sum_d   = sum_q;
            carry_d = carry_q;
        end
    end

    // Registered LED outputs.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign o_LED_Sum   = sum_q;
    assign o_LED_Carry = carry_q;
    assign o_Busy      = (state_q == WAIT_REL);

endmodule

// File: tb/tb_switch_accum_adder.sv
// Bench for switch_accum_adder: three instances (2-bit wrap, 2-bit saturate,
// 8-bit wrap) share the same buttons and operand switches, and each is compared
// against an arithmetic model of the accumulator.
module tb_switch_accum_adder;

    localparam int LIMIT = 4;
    localparam int LAT   = LIMIT + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] opd;
    logic       add_sw;
    logic       sub_sw;
    logic       clr_sw;

    logic [1:0] sum_a;
    logic [1:0] sum_b;
    logic [7:0] sum_c;
    logic       carry_a, carry_b, carry_c;
    logic       busy_a, busy_b, busy_c;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    int m_sum   [3];
    int m_carry [3];
    int m_w     [3] = '{2, 2, 8};
    int m_sat   [3] = '{0, 1, 0};
    int cur_opd;

    always #5 clk = ~clk;

    switch_accum_adder #(.WIDTH(2), .DEBOUNCE_LIMIT(LIMIT), .SATURATE(0)) u_w2s0 (
        .i_Clk(clk), .i_Reset(rst), .i_Operand(opd[1:0]),
        .i_Add_Sw(add_sw), .i_Sub_Sw(sub_sw), .i_Clr_Sw(clr_sw),
        .o_LED_Sum(sum_a), .o_LED_Carry(carry_a), .o_Busy(busy_a)
    );

    switch_accum_adder #(.WIDTH(2), .DEBOUNCE_LIMIT(LIMIT), .SATURATE(1)) u_w2s1 (
        .i_Clk(clk), .i_Reset(rst), .i_Operand(opd[1:0]),
        .i_Add_Sw(add_sw), .i_Sub_Sw(sub_sw), .i_Clr_Sw(clr_sw),
        .o_LED_Sum(sum_b), .o_LED_Carry(carry_b), .o_Busy(busy_b)
    );

    switch_accum_adder #(.WIDTH(8), .DEBOUNCE_LIMIT(LIMIT), .SATURATE(0)) u_w8s0 (
        .i_Clk(clk), .i_Reset(rst), .i_Operand(opd),
        .i_Add_Sw(add_sw), .i_Sub_Sw(sub_sw), .i_Clr_Sw(clr_sw),
        .o_LED_Sum(sum_c), .o_LED_Carry(carry_c), .o_Busy(busy_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference accumulator: integer arithmetic on the button rules.
    task automatic model_apply(input logic a, input logic s, input logic c, input int v);
        for (int i = 0; i < 3; i++) begin
            int modv;
            int o;
            int t;
            modv = 1 << m_w[i];
            o    = v % modv;
            if (c) begin
                m_sum[i]   = 0;
                m_carry[i] = 0;
            end else if (a && s) begin
                m_sum[i] = m_sum[i];
            end else if (a) begin
                t = m_sum[i] + o;
                m_carry[i] = (t >= modv) ? 1 : 0;
                if (t >= modv) m_sum[i] = (m_sat[i] != 0) ? modv - 1 : t - modv;
                else           m_sum[i] = t;
            end else if (s) begin
                t = m_sum[i] - o;
                m_carry[i] = (t < 0) ? 1 : 0;
                if (t < 0) m_sum[i] = (m_sat[i] != 0) ? 0 : t + modv;
                else       m_sum[i] = t;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_sum[i]   = 0;
            m_carry[i] = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_sum_a"},   sum_a,   m_sum[0]);
        check({tag, "_carry_a"}, carry_a, m_carry[0]);
        check({tag, "_sum_b"},   sum_b,   m_sum[1]);
        check({tag, "_carry_b"}, carry_b, m_carry[1]);
        check({tag, "_sum_c"},   sum_c,   m_sum[2]);
        check({tag, "_carry_c"}, carry_c, m_carry[2]);
    endtask

    task automatic set_operand(input int v);
        cur_opd = v;
        opd     = v[7:0];
        repeat (3) @(negedge clk);
    endtask

    // Press buttons cleanly and wait (bounded) for the operation to execute.
    task automatic push(input logic a, input logic s, input logic c, input string tag);
        int n;
        add_sw = a;
        sub_sw = s;
        clr_sw = c;
        n = 0;
        while (busy_a !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n, LAT);
        check({tag, "_busy_c"}, busy_c, 1'b1);
        model_apply(a, s, c, cur_opd);
        check_all(tag);
    endtask

    // Release everything and wait (bounded) for the FSM to return to idle.
    task automatic release_all(input string tag, input int exp_lat);
        int n;
        add_sw = 1'b0;
        sub_sw = 1'b0;
        clr_sw = 1'b0;
        n = 0;
        while (busy_a !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rel_lat"}, n, exp_lat);
        check({tag, "_rel_busy_b"}, busy_b, 1'b0);
        check_all({tag, "_rel"});
    endtask

    task automatic press(input logic a, input logic s, input logic c, input string tag);
        push(a, s, c, tag);
        release_all(tag, LAT);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int early_busy;
        rst = 1'b1; opd = 8'd0; add_sw = 1'b0; sub_sw = 1'b0; clr_sw = 1'b0;
        cur_opd = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy_a", busy_a, 1'b0);
        check("rst_busy_c", busy_c, 1'b0);
        check_all("rst");

        // Bouncing add button, then a clean hold: exactly one add of 3.
        set_operand(3);
        add_sw = 1'b1; @(negedge clk);
        add_sw = 1'b0; @(negedge clk);
        add_sw = 1'b1; @(negedge clk);
        add_sw = 1'b0; @(negedge clk);
        add_sw = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        check("bounce_busy_early", busy_a, 1'b0);
        check("bounce_sum_early", sum_a, 2'd0);
        repeat (10 - (LAT - 1)) @(negedge clk);
        check("bounce_busy", busy_a, 1'b1);
        check("bounce_sum", sum_a, 2'd3);
        check("bounce_carry", carry_a, 1'b0);
        model_apply(1'b1, 1'b0, 1'b0, 3);
        check_all("bounce");
        add_sw = 1'b0;
        repeat (3) @(negedge clk);
        check("bounce_busy_held", busy_a, 1'b1);
        release_all("bounce", LAT - 3);

        // Wrap versus saturate with three adds of 2.
        press(1'b0, 1'b0, 1'b1, "clr2");
        set_operand(2);
        push(1'b1, 1'b0, 1'b0, "wrap1");
        check("wrap1_a", {sum_a, carry_a}, {2'd2, 1'b0});
        check("wrap1_b", {sum_b, carry_b}, {2'd2, 1'b0});
        release_all("wrap1", LAT);
        push(1'b1, 1'b0, 1'b0, "wrap2");
        check("wrap2_a", {sum_a, carry_a}, {2'd0, 1'b1});
        check("wrap2_b", {sum_b, carry_b}, {2'd3, 1'b1});
        release_all("wrap2", LAT);
        push(1'b1, 1'b0, 1'b0, "wrap3");
        check("wrap3_a", {sum_a, carry_a}, {2'd2, 1'b0});
        check("wrap3_b", {sum_b, carry_b}, {2'd3, 1'b1});
        release_all("wrap3", LAT);

        // Borrow: 1 - 3.
        press(1'b0, 1'b0, 1'b1, "clr3");
        set_operand(1);
        press(1'b1, 1'b0, 1'b0, "set1");
        set_operand(3);
        push(1'b0, 1'b1, 1'b0, "borrow");
        check("borrow_a", {sum_a, carry_a}, {2'd2, 1'b1});
        check("borrow_b", {sum_b, carry_b}, {2'd0, 1'b1});
        release_all("borrow", LAT);

        // Priority: clear beats add; add+sub together is a no-op.
        press(1'b0, 1'b0, 1'b1, "clr4");
        press(1'b1, 1'b0, 1'b0, "set3");
        push(1'b1, 1'b0, 1'b1, "clr_add");
        check("clr_add_a", {sum_a, carry_a}, {2'd0, 1'b0});
        release_all("clr_add", LAT);
        press(1'b1, 1'b0, 1'b0, "add3");
        set_operand(2);
        press(1'b1, 1'b0, 1'b0, "add2");
        push(1'b1, 1'b1, 1'b0, "add_sub");
        check("add_sub_a", {sum_a, carry_a}, {2'd1, 1'b1});
        release_all("add_sub", LAT);

        // 8-bit wrap: 200 + 100.
        press(1'b0, 1'b0, 1'b1, "clr8");
        set_operand(200);
        press(1'b1, 1'b0, 1'b0, "add200");
        set_operand(100);
        push(1'b1, 1'b0, 1'b0, "add100");
        check("add100_c", {sum_c, carry_c}, {8'd44, 1'b1});
        release_all("add100", LAT);

        // Hold add, press sub while held: only the add executes.
        press(1'b0, 1'b0, 1'b1, "clr5");
        set_operand(1);
        push(1'b1, 1'b0, 1'b0, "hold");
        sub_sw = 1'b1;
        repeat (12) @(negedge clk);
        check("hold_sub_busy", busy_a, 1'b1);
        check("hold_sub_sum", sum_a, 2'd1);
        check_all("hold_sub");
        sub_sw = 1'b0;
        repeat (12) @(negedge clk);
        check("hold_only_busy", busy_a, 1'b1);
        check_all("hold_only");
        release_all("hold", LAT);

        // Reset while waiting for release with add held.
        set_operand(2);
        push(1'b1, 1'b0, 1'b0, "pre_rst");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("midrst_busy_a", busy_a, 1'b0);
        check("midrst_busy_c", busy_c, 1'b0);
        check_all("midrst");
        early_busy = 0;
        for (int i = 0; i < LIMIT + 2; i++) begin
            @(negedge clk);
            if (busy_a !== 1'b0 || sum_a !== 2'd0) early_busy++;
        end
        check("midrst_no_early_op", early_busy, 0);
        @(negedge clk);
        check("midrst_reexec_busy", busy_a, 1'b1);
        check("midrst_reexec_sum", sum_a, 2'd2);
        model_apply(1'b1, 1'b0, 1'b0, cur_opd);
        check_all("midrst_reexec");
        release_all("midrst", LAT);

        // Random button combinations and operands.
        for (int r = 0; r < 20; r++) begin
            logic [2:0] bits;
            set_operand(int'($urandom_range(0, 255)));
            bits = 3'($urandom_range(1, 7));
            press(bits[0], bits[1], bits[2], $sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
